// File: rtl/seq_mul_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_datapath_if
// Brief    : Result valid/ready channel carrying the finished product.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_mul_datapath_if #(
    parameter int WIDTH = 8
);
    logic [2*WIDTH-1:0] res_data;
    logic               res_valid;
    logic               res_ready;

    modport master (
        output res_data,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  res_data,
        input  res_valid,
        output res_ready
    );
endinterface
`default_nettype wire

// File: rtl/seq_mul_datapath.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_datapath
// Brief    : Shift-free sequential multiplier datapath (repeated add of A into
//            F while B counts down) with a one-entry result hold register.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mul_datapath #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] a_in,
    input  wire logic [WIDTH-1:0] b_in,
    input  wire logic             load_a,
    input  wire logic             load_b,
    input  wire logic             dec_b,
    input  wire logic             load_f,
    output logic                  zero,
    seq_mul_datapath_if.master    res,
    output logic                  res_drop,
    output logic                  busy
);

    localparam logic [WIDTH-1:0] c_b_one  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_a_zext = '0;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_f;
    logic [2*WIDTH-1:0] r_res_data;
    logic               r_res_valid;
    logic               r_res_drop;
    logic               r_busy;

    logic w_iterate;
    logic w_b_zero;
    logic w_step;
    logic w_capture;
    logic w_xfer;

    // Loads take precedence: iterate strobes are ignored whenever A or B loads.
    assign w_iterate = dec_b & load_f & ~load_a & ~load_b;
    assign w_b_zero  = (r_b == '0);
    assign w_step    = w_iterate & ~w_b_zero;
    assign w_capture = w_iterate &  w_b_zero;
    assign w_xfer    = r_res_valid & res.res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_f         <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_res_drop  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (load_a) begin
                r_a    <= a_in;
                r_f    <= '0;
                r_busy <= 1'b1;
            end else if (w_step) begin
                r_f <= r_f + {c_a_zext, r_a};
            end

            if (load_b) begin
                r_b <= b_in;
            end else if (w_step) begin
                r_b <= r_b - c_b_one;
            end

            // A capture into an occupied, stalled slot loses the new product.
            if (w_capture) begin
                r_busy <= 1'b0;
                if (!r_res_valid || res.res_ready) begin
                    r_res_data  <= r_f;
                    r_res_valid <= 1'b1;
                end else begin
                    r_res_drop <= 1'b1;
                end
            end else if (w_xfer) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign zero          = w_b_zero;
    assign res.res_data  = r_res_data;
    assign res.res_valid = r_res_valid;
    assign res_drop      = r_res_drop;
    assign busy          = r_busy;

endmodule
`default_nettype wire
